// File: rtl/connection_block_cfg.sv
// connection_block_cfg
//   Routing connection block between two CLBs and the surrounding single,
//   double and global tracks, with a beat-serial configuration chain.
//
//   Configuration path: cfg_din beats shift into a shadow register.
//   Once NBEATS beats are held (cfg_ready), cfg_commit copies the shadow
//   into the active configuration. A commit before that, or a commit in
//   the same cycle as a shift, sets the sticky cfg_err flag.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     cset                     1 = active configuration drives routing
//     single0/1_in, _out       single tracks (WS per direction)
//     double0/1_in, _out       double tracks (WD per direction)
//     global_in                global lines (WG)
//     clb0/1_output            CLB outputs feeding the block
//     clb0/1_cout, clb0/1_cin  carry chain between the two CLBs
//     clb0/1_input             routed CLB inputs
//     cfg_shift, cfg_din       configuration beat strobe and data
//     cfg_commit               shadow -> active copy request
//     cfg_dout                 chain output (shadow LSBs)
//     cfg_ready, cfg_err       full shadow / sticky protocol error
module connection_block_cfg #(
    parameter int WS         = 8,
    parameter int WD         = 8,
    parameter int WG         = 4,
    parameter int CLBIN0     = 4,
    parameter int CLBIN1     = 4,
    parameter int CLBOUT0    = 2,
    parameter int CLBOUT1    = 2,
    parameter int CLBOS      = 2,
    parameter int CLBOD      = 2,
    parameter int CLBOS_BIAS = 1,
    parameter int CLBOD_BIAS = 0,
    parameter int CFG_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cset,
    input  logic [WS-1:0]      single0_in,
    input  logic [WS-1:0]      single1_in,
    output logic [WS-1:0]      single0_out,
    output logic [WS-1:0]      single1_out,
    input  logic [WD-1:0]      double0_in,
    input  logic [WD-1:0]      double1_in,
    output logic [WD-1:0]      double0_out,
    output logic [WD-1:0]      double1_out,
    input  logic [WG-1:0]      global_in,
    input  logic [CLBOUT0-1:0] clb0_output,
    input  logic [CLBOUT1-1:0] clb1_output,
    input  logic               clb0_cout,
    input  logic               clb1_cout,
    output logic               clb0_cin,
    output logic               clb1_cin,
    output logic [CLBIN0-1:0]  clb0_input,
    output logic [CLBIN1-1:0]  clb1_input,
    input  logic               cfg_shift,
    input  logic [CFG_W-1:0]   cfg_din,
    input  logic               cfg_commit,
    output logic [CFG_W-1:0]   cfg_dout,
    output logic               cfg_ready,
    output logic               cfg_err
);

    localparam int NIN0   = 2 * (WS + WD) + WG + CLBOUT1;
    localparam int NIN1   = 2 * (WS + WD) + WG + CLBOUT0;
    localparam int SI0    = $clog2(NIN0);
    localparam int SI1    = $clog2(NIN1);
    localparam int NOUT   = CLBOUT0 + CLBOUT1;
    localparam int SO     = $clog2(NOUT + 1);
    localparam int CB     = SI0 * CLBIN0 + SI1 * CLBIN1
                          + 2 * SO * (CLBOS + CLBOD) + 2 * (CLBOS + CLBOD);
    localparam int NBEATS = (CB + CFG_W - 1) / CFG_W;
    localparam int SHW    = NBEATS * CFG_W;
    localparam int CNT_W  = $clog2(NBEATS + 1);

    // Field offsets inside the active configuration word, LSB first
    localparam int OFF_C1 = SI0 * CLBIN0;
    localparam int OFF_S1 = OFF_C1 + SI1 * CLBIN1;
    localparam int OFF_S0 = OFF_S1 + SO * CLBOS;
    localparam int OFF_D1 = OFF_S0 + SO * CLBOS;
    localparam int OFF_D0 = OFF_D1 + SO * CLBOD;
    localparam int EN_S1  = OFF_D0 + SO * CLBOD;
    localparam int EN_S0  = EN_S1 + CLBOS;
    localparam int EN_D1  = EN_S0 + CLBOS;
    localparam int EN_D0  = EN_D1 + CLBOD;

    // Beat counter states: anything strictly between is LOADING
    localparam logic [CNT_W-1:0] ST_EMPTY = '0;
    localparam logic [CNT_W-1:0] ST_FULL  = CNT_W'(NBEATS);

    logic [SHW-1:0]   shadow_q, shadow_d;
    logic [CB-1:0]    active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // ---------------- configuration chain ----------------
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (cfg_commit) begin
            if (cnt_q == ST_FULL) begin
                active_d = shadow_q[CB-1:0];
                cnt_d    = ST_EMPTY;
            end else begin
                err_d = 1'b1;
            end
            // A simultaneous shift beat is dropped and flagged
            if (cfg_shift) begin
                err_d = 1'b1;
            end
        end else if (cfg_shift) begin
            shadow_d = {cfg_din, shadow_q[SHW-1:CFG_W]};
            if (cnt_q != ST_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= ST_EMPTY;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign cfg_dout  = shadow_q[CFG_W-1:0];
    assign cfg_ready = (cnt_q == ST_FULL);
    assign cfg_err   = err_q;

    // ---------------- carry ----------------
    assign clb0_cin = clb1_cout;
    assign clb1_cin = clb0_cout;

    // ---------------- CLB input muxes ----------------
    logic [NIN0-1:0] cand0;
    logic [NIN1-1:0] cand1;
    assign cand0 = {clb1_output, global_in, double1_in, double0_in, single1_in, single0_in};
    assign cand1 = {clb0_output, global_in, double1_in, double0_in, single1_in, single0_in};

    generate
        for (genvar gi = 0; gi < CLBIN0; gi++) begin : g_c0in
            logic [SI0-1:0] sel;
            assign sel            = active_q[gi*SI0 +: SI0];
            assign clb0_input[gi] = cset & (int'(sel) < NIN0) & cand0[sel];
        end
        for (genvar gi = 0; gi < CLBIN1; gi++) begin : g_c1in
            logic [SI1-1:0] sel;
            assign sel            = active_q[OFF_C1 + gi*SI1 +: SI1];
            assign clb1_input[gi] = cset & (int'(sel) < NIN1) & cand1[sel];
        end
    endgenerate

    // ---------------- track drivers ----------------
    // Select 0 keeps the track straight-through; 1..NOUT picks a CLB output.
    function automatic logic out_mux(input logic [SO-1:0] sel, input logic thru,
                                     input logic [NOUT-1:0] src);
        logic r;
        int   s;
        s = int'(sel);
        if (s == 0)         r = thru;
        else if (s <= NOUT) r = src[s-1];
        else                r = 1'b0;
        return r;
    endfunction

    logic [NOUT-1:0]  clb_cat;
    logic [CLBOS-1:0] s1_d, s0_d, s1_q, s0_q, s1_val, s0_val;
    logic [CLBOD-1:0] d1_d, d0_d, d1_q, d0_q, d1_val, d0_val;
    assign clb_cat = {clb1_output, clb0_output};

    generate
        for (genvar gi = 0; gi < CLBOS; gi++) begin : g_single
            localparam int K = (gi + CLBOS_BIAS * CLBOS) % WS;
            assign s1_d[gi]   = out_mux(active_q[OFF_S1 + gi*SO +: SO], single0_in[K], clb_cat);
            assign s0_d[gi]   = out_mux(active_q[OFF_S0 + gi*SO +: SO], single1_in[K], clb_cat);
            assign s1_val[gi] = active_q[EN_S1 + gi] ? s1_q[gi] : s1_d[gi];
            assign s0_val[gi] = active_q[EN_S0 + gi] ? s0_q[gi] : s0_d[gi];
        end
        for (genvar gi = 0; gi < CLBOD; gi++) begin : g_double
            localparam int K = (gi + CLBOD_BIAS * CLBOD) % (WD / 2);
            assign d1_d[gi]   = out_mux(active_q[OFF_D1 + gi*SO +: SO], double0_in[K], clb_cat);
            assign d0_d[gi]   = out_mux(active_q[OFF_D0 + gi*SO +: SO], double1_in[K], clb_cat);
            assign d1_val[gi] = active_q[EN_D1 + gi] ? d1_q[gi] : d1_d[gi];
            assign d0_val[gi] = active_q[EN_D0 + gi] ? d0_q[gi] : d0_d[gi];
        end
    endgenerate

    // Track flops run every cycle; the enable bit only chooses which copy is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s0_q <= '0;
            d1_q <= '0;
            d0_q <= '0;
        end else begin
            s1_q <= s1_d;
            s0_q <= s0_d;
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    // Straight-through everywhere, then overlay driven tracks when configured
    always_comb begin
        single1_out = single0_in;
        single0_out = single1_in;
        double1_out = double0_in;
        double0_out = double1_in;
        if (cset) begin
            for (int i = 0; i < CLBOS; i++) begin
                single1_out[(i + CLBOS_BIAS * CLBOS) % WS] = s1_val[i];
                single0_out[(i + CLBOS_BIAS * CLBOS) % WS] = s0_val[i];
            end
            for (int i = 0; i < CLBOD; i++) begin
                double1_out[(i + CLBOD_BIAS * CLBOD) % (WD / 2)] = d1_val[i];
                double0_out[(i + CLBOD_BIAS * CLBOD) % (WD / 2)] = d0_val[i];
            end
        end
    end

endmodule

// File: tb/tb_connection_block_cfg.sv
module tb_connection_block_cfg;

    logic       clk = 1'b0;
    logic       rst, cset;
    logic [7:0] single0_in, single1_in, single0_out, single1_out;
    logic [7:0] double0_in, double1_in, double0_out, double1_out;
    logic [3:0] global_in;
    logic [1:0] clb0_output, clb1_output;
    logic       clb0_cout, clb1_cout, clb0_cin, clb1_cin;
    logic [3:0] clb0_input, clb1_input;
    logic       cfg_shift, cfg_commit, cfg_ready, cfg_err;
    logic [7:0] cfg_din, cfg_dout;

    always #5 clk = ~clk;

    connection_block_cfg dut (
        .clk(clk), .rst(rst), .cset(cset),
        .single0_in(single0_in), .single1_in(single1_in),
        .single0_out(single0_out), .single1_out(single1_out),
        .double0_in(double0_in), .double1_in(double1_in),
        .double0_out(double0_out), .double1_out(double1_out),
        .global_in(global_in),
        .clb0_output(clb0_output), .clb1_output(clb1_output),
        .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
        .clb0_cin(clb0_cin), .clb1_cin(clb1_cin),
        .clb0_input(clb0_input), .clb1_input(clb1_input),
        .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_commit(cfg_commit),
        .cfg_dout(cfg_dout), .cfg_ready(cfg_ready), .cfg_err(cfg_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_beat(input logic [7:0] d);
        cfg_shift = 1'b1;
        cfg_din   = d;
        step();
        cfg_shift = 1'b0;
    endtask

    task automatic commit_pulse();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic load_cfg(input logic [79:0] v);
        for (int b = 0; b < 10; b++) shift_beat(v[b*8 +: 8]);
        commit_pulse();
    endtask

    function automatic logic [79:0] put(input logic [79:0] v, input int off,
                                        input int w, input int val);
        logic [79:0] r;
        r = v;
        for (int b = 0; b < w; b++) r[off + b] = val[b];
        return r;
    endfunction

    typedef struct {
        logic        load;
        logic [79:0] cfg;
        logic        cs;
        logic [7:0]  s0, s1, d0, d1;
        logic [3:0]  g;
        logic [1:0]  c0, c1;
        logic [3:0]  e_c0, e_c1;
        logic [7:0]  e_s0, e_s1, e_d0, e_d1;
    } vec_t;

    vec_t        vt[6];
    logic [79:0] cfg_a, cfg_b, cfg_c, cfg_x;

    initial begin
        // Field offsets: clb0 sel 6j, clb1 sel 24+6j, s1 drv 48+3i, s0 drv 54+3i,
        // d1 drv 60+3i, d0 drv 66+3i, enables s1 72+i, s0 74+i, d1 76+i, d0 78+i.
        cfg_a = '0;
        cfg_b = '0;
        cfg_b = put(cfg_b, 0, 6, 32);  cfg_b = put(cfg_b, 6, 6, 8);
        cfg_b = put(cfg_b, 12, 6, 36); cfg_b = put(cfg_b, 18, 6, 37);
        cfg_b = put(cfg_b, 24, 6, 37); cfg_b = put(cfg_b, 30, 6, 40);
        cfg_b = put(cfg_b, 36, 6, 24); cfg_b = put(cfg_b, 42, 6, 63);
        cfg_c = '0;
        cfg_c = put(cfg_c, 48, 3, 1); cfg_c = put(cfg_c, 51, 3, 4);
        cfg_c = put(cfg_c, 54, 3, 2); cfg_c = put(cfg_c, 57, 3, 7);
        cfg_c = put(cfg_c, 60, 3, 3); cfg_c = put(cfg_c, 63, 3, 0);
        cfg_c = put(cfg_c, 66, 3, 5); cfg_c = put(cfg_c, 69, 3, 1);

        //          load cfg   cs  s0     s1     d0     d1     g     c0     c1     e_c0  e_c1  e_s0   e_s1   e_d0   e_d1
        vt[0] = '{1'b1, cfg_a, 1'b1, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 4'h9, 2'b01, 2'b10, 4'hF, 4'hF, 8'h3C, 8'hA5, 8'hF0, 8'h0F};
        vt[1] = '{1'b1, cfg_b, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 4'h1, 2'b10, 2'b01, 4'h7, 4'h5, 8'h01, 8'h00, 8'h01, 8'h00};
        vt[2] = '{1'b0, cfg_b, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 4'h1, 2'b10, 2'b01, 4'h0, 4'h0, 8'h01, 8'h00, 8'h01, 8'h00};
        vt[3] = '{1'b0, cfg_b, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 4'h1, 2'b10, 2'b01, 4'h7, 4'h5, 8'h01, 8'h00, 8'h01, 8'h00};
        vt[4] = '{1'b1, cfg_c, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 4'h0, 2'b01, 2'b10, 4'h0, 4'h0, 8'hF3, 8'h0C, 8'h02, 8'hFE};
        vt[5] = '{1'b0, cfg_c, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 4'h0, 2'b01, 2'b10, 4'h0, 4'h0, 8'hFF, 8'h00, 8'h00, 8'hFF};

        // ---------------- reset ----------------
        rst = 1'b1; cset = 1'b1; cfg_shift = 1'b0; cfg_commit = 1'b0; cfg_din = '0;
        single0_in = 8'h5B; single1_in = 8'hC6; double0_in = 8'h39; double1_in = 8'hE2;
        global_in = 4'hA; clb0_output = 2'b10; clb1_output = 2'b01;
        clb0_cout = 1'b1; clb1_cout = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        chk("rst_s1out", 32'(single1_out), 32'h5B);
        chk("rst_s0out", 32'(single0_out), 32'hC6);
        chk("rst_d1out", 32'(double1_out), 32'h39);
        chk("rst_d0out", 32'(double0_out), 32'hE2);
        chk("rst_c0in", 32'(clb0_input), 32'hF);
        chk("rst_ready", 32'(cfg_ready), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);
        chk("rst_dout", 32'(cfg_dout), 32'h0);
        chk("carry0", 32'({clb0_cin, clb1_cin}), 32'h1);
        clb0_cout = 1'b0; clb1_cout = 1'b1;
        #1;
        chk("carry1", 32'({clb0_cin, clb1_cin}), 32'h2);

        // ---------------- table-driven routing vectors ----------------
        for (int i = 0; i < 6; i++) begin
            if (vt[i].load) load_cfg(vt[i].cfg);
            cset = vt[i].cs;
            single0_in = vt[i].s0; single1_in = vt[i].s1;
            double0_in = vt[i].d0; double1_in = vt[i].d1;
            global_in = vt[i].g; clb0_output = vt[i].c0; clb1_output = vt[i].c1;
            #1;
            chk($sformatf("v%0d_c0in", i), 32'(clb0_input), 32'(vt[i].e_c0));
            chk($sformatf("v%0d_c1in", i), 32'(clb1_input), 32'(vt[i].e_c1));
            chk($sformatf("v%0d_s0out", i), 32'(single0_out), 32'(vt[i].e_s0));
            chk($sformatf("v%0d_s1out", i), 32'(single1_out), 32'(vt[i].e_s1));
            chk($sformatf("v%0d_d0out", i), 32'(double0_out), 32'(vt[i].e_d0));
            chk($sformatf("v%0d_d1out", i), 32'(double1_out), 32'(vt[i].e_d1));
            step();
        end

        // ---------------- full load with saturation: select 32 -> global[0] ----------------
        cset = 1'b1; single0_in = 8'h00; single1_in = 8'h00; global_in = 4'b0001;
        cfg_x = put(80'd0, 0, 6, 32);
        #1;
        chk("full_pre_c0in0", 32'(clb0_input[0]), 32'h0);
        shift_beat(8'hFF);                       // extra leading beat, pushed out by saturation
        for (int b = 0; b < 8; b++) shift_beat(cfg_x[b*8 +: 8]);
        chk("full_ready_9", 32'(cfg_ready), 32'h0);
        shift_beat(cfg_x[8*8 +: 8]);
        chk("full_ready_10", 32'(cfg_ready), 32'h1);
        chk("full_c0in0_held", 32'(clb0_input[0]), 32'h0);
        shift_beat(cfg_x[9*8 +: 8]);
        chk("full_ready_sat", 32'(cfg_ready), 32'h1);
        chk("full_dout", 32'(cfg_dout), 32'h20);
        commit_pulse();
        chk("full_c0in0_new", 32'(clb0_input[0]), 32'h1);
        chk("full_ready_post", 32'(cfg_ready), 32'h0);
        chk("full_err", 32'(cfg_err), 32'h0);

        // ---------------- early commit: select 8 -> single1_in[0] ----------------
        cfg_x = put(80'd0, 0, 6, 8);
        for (int b = 0; b < 5; b++) shift_beat(cfg_x[b*8 +: 8]);
        commit_pulse();
        chk("early_err", 32'(cfg_err), 32'h1);
        chk("early_c0in0", 32'(clb0_input[0]), 32'h1);
        chk("early_ready", 32'(cfg_ready), 32'h0);
        for (int b = 5; b < 10; b++) shift_beat(cfg_x[b*8 +: 8]);
        chk("late_ready", 32'(cfg_ready), 32'h1);
        commit_pulse();
        chk("late_c0in0", 32'(clb0_input[0]), 32'h0);
        chk("late_err_sticky", 32'(cfg_err), 32'h1);

        // ---------------- registered track: single1_out[2] select 1 ----------------
        clb0_output = 2'b00; single0_in = 8'h00;
        cfg_x = put(80'd0, 48, 3, 1);
        cfg_x = put(cfg_x, 72, 1, 1);
        load_cfg(cfg_x);
        step();
        clb0_output = 2'b01;
        #1;
        chk("reg_rise_same", 32'(single1_out[2]), 32'h0);
        step();
        chk("reg_rise_next", 32'(single1_out[2]), 32'h1);
        clb0_output = 2'b00;
        #1;
        chk("reg_fall_same", 32'(single1_out[2]), 32'h1);
        step();
        chk("reg_fall_next", 32'(single1_out[2]), 32'h0);
        cfg_x = put(cfg_x, 72, 1, 0);
        load_cfg(cfg_x);
        clb0_output = 2'b01;
        #1;
        chk("comb_rise", 32'(single1_out[2]), 32'h1);
        clb0_output = 2'b00;
        #1;
        chk("comb_fall", 32'(single1_out[2]), 32'h0);

        // ---------------- mid-load reset ----------------
        for (int b = 0; b < 6; b++) shift_beat(8'hFF);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(cfg_dout), 32'h0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'h0);
        chk("mid_rst_err", 32'(cfg_err), 32'h0);
        step();
        single0_in = 8'h00; global_in = 4'b0010;
        cfg_x = put(80'd0, 0, 6, 33);
        for (int b = 0; b < 9; b++) shift_beat(cfg_x[b*8 +: 8]);
        chk("mid_ready_9", 32'(cfg_ready), 32'h0);
        shift_beat(cfg_x[9*8 +: 8]);
        chk("mid_ready_10", 32'(cfg_ready), 32'h1);
        commit_pulse();
        chk("mid_c0in", 32'(clb0_input), 32'h1);
        chk("mid_err", 32'(cfg_err), 32'h0);

        // ---------------- shift and commit together ----------------
        cfg_shift = 1'b1; cfg_din = 8'hAA; cfg_commit = 1'b1;
        step();
        cfg_shift = 1'b0; cfg_commit = 1'b0;
        chk("both_err", 32'(cfg_err), 32'h1);
        chk("both_dout_kept", 32'(cfg_dout), 32'h21);
        chk("both_c0in_kept", 32'(clb0_input), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/connection_block_cfg.md
CONNECTION_BLOCK_CFG -- requirements
Module: connection_block_cfg

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WS, 8, single tracks per direction
- WD, 8, double tracks per direction
- WG, 4, global lines
- CLBIN0 / CLBIN1, 4 / 4, routed inputs of CLB0 / CLB1
- CLBOUT0 / CLBOUT1, 2 / 2, outputs of CLB0 / CLB1
- CLBOS / CLBOD, 2 / 2, CLB-drivable single / double tracks per direction
- CLBOS_BIAS / CLBOD_BIAS, 1 / 0, driven-track offset multipliers
- CFG_W, 8, configuration bits per shift beat

REQ-002 Derived constants SHALL be:
- NIN0 = 2(WS+WD)+WG+CLBOUT1; NIN1 = 2(WS+WD)+WG+CLBOUT0
- SI0 = clog2(NIN0); SI1 = clog2(NIN1); SO = clog2(CLBOUT0+CLBOUT1+1)
- CB = SI0·CLBIN0 + SI1·CLBIN1 + 2·SO·(CLBOS+CLBOD) + 2·(CLBOS+CLBOD)
- NBEATS = ceil(CB/CFG_W)
- At defaults: SI=6, SO=3, CB=80, NBEATS=10.

REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cset  in  1  1 = active configuration applied; 0 = default routing
- single0_in, single1_in  in  WS  incoming singles; single0_out, single1_out  out  WS
- double0_in, double1_in  in  WD; double0_out, double1_out  out  WD
- global  in  WG
- clb0_output  in  CLBOUT0; clb1_output  in  CLBOUT1
- clb0_cout, clb1_cout  in  1; clb0_cin, clb1_cin  out  1
- clb0_input  out  CLBIN0; clb1_input  out  CLBIN1
- cfg_shift  in  1  shift beat strobe; cfg_din  in  CFG_W  beat data
- cfg_commit  in  1  copy shadow to active
- cfg_dout  out  CFG_W  chain output (shadow LSBs)
- cfg_ready  out  1  NBEATS beats held
- cfg_err  out  1  sticky protocol error

Function
REQ-004 Carry SHALL be combinational: clb0_cin = clb1_cout, clb1_cin = clb0_cout.

REQ-005 Shadow register SHALL be NBEATS·CFG_W bits wide. On cfg_shift it SHALL shift right by CFG_W with cfg_din entering at the MSBs. cfg_dout SHALL equal the shadow bits [CFG_W-1:0].

REQ-006 Beat counter SHALL implement states EMPTY (0), LOADING (1..NBEATS-1) and FULL (NBEATS):
- each shift increments the counter
- the counter saturates at FULL while shifting continues
- cfg_ready = FULL

REQ-007 cfg_commit in FULL SHALL load active <= shadow[CB-1:0] at that edge and return the counter to EMPTY. The new routing SHALL take effect after the edge.

REQ-008 cfg_commit in EMPTY or LOADING SHALL be rejected: active unchanged, counter unchanged, cfg_err <= 1.

REQ-009 cfg_shift and cfg_commit asserted in the same cycle SHALL be treated as follows:
- commit is evaluated against the pre-edge counter
- the shift beat is discarded
- cfg_err <= 1 regardless of commit outcome

REQ-010 Active bit layout, LSB first, SHALL be:
- CLBIN0 fields of SI0 bits
- CLBIN1 fields of SI1 bits
- CLBOS SO-bit fields driving single1_out
- CLBOS SO-bit fields driving single0_out
- CLBOD SO-bit fields driving double1_out
- CLBOD SO-bit fields driving double0_out
- 2·(CLBOS+CLBOD) register-enable bits, in the same order

REQ-011 CLB0 input candidates, index 0 upward, SHALL be single0_in, single1_in, double0_in, double1_in, global, clb1_output. CLB1 candidates SHALL be the same with clb0_output in last position. A select of NIN or above SHALL drive 0.

REQ-012 Driven tracks SHALL be:
- singles: k = (i + CLBOS_BIAS·CLBOS) mod WS
- doubles: k = (i + CLBOD_BIAS·CLBOD) mod (WD/2)
- output select 0 = straight-through (single1_out[k] = single0_in[k], and symmetrically)
- select s in 1..CLBOUT0+CLBOUT1 = {clb1_output, clb0_output}[s-1]
- select above that range = 0

REQ-013 All undriven tracks, and all double indices at or above WD/2, SHALL pass straight through combinationally.

REQ-014 A driven track with its register-enable bit set SHALL output a flop of its mux result, giving 1-cycle latency. With the bit clear, the output SHALL be combinational.

REQ-015 cset = 0 SHALL force the following without altering stored state:
- every track straight-through
- all CLB inputs 0
- registers bypassed

Reset
REQ-016 rst SHALL asynchronously clear shadow, active, counter, cfg_err and all track flops to 0. Reset outputs SHALL therefore be:
- straight-through tracks
- clb0_input = {CLBIN0{single0_in[0]}} when cset = 1
- cfg_ready = 0, cfg_err = 0, cfg_dout = 0

REQ-017 rst asserted mid-load SHALL discard the partial load. The next load SHALL start at EMPTY.

Verification
REQ-018 Reset: rst pulse, cset = 1, random inputs -> all four track pairs straight-through, clb0_input = 4×single0_in[0], cfg_ready = 0, cfg_err = 0.

REQ-019 Full load: 10 beats placing select 32 in clb0_input[0] -> cfg_ready = 1 after beat 10, clb0_input[0] unchanged until commit, = global[0] after the commit edge, cfg_ready = 0 after commit.

REQ-020 Early commit after 5 beats -> cfg_err = 1, routing unchanged. 5 more beats, then commit -> accepted, cfg_err stays 1.

REQ-021 Registered track: single1_out[2] select 1 with enable set, toggle clb0_output[0] -> single1_out[2] follows exactly one clk later. Same with enable clear -> follows the same cycle.

REQ-022 Bounds: clb1_input select 40 -> 0; output select 7 -> 0; cset = 0 -> defaults, and the active configuration is restored when cset returns to 1.

REQ-023 Mid-load reset after 6 beats, then 10 beats and commit -> only the post-reset beats take effect. Shift and commit in the same cycle -> cfg_err = 1.
